pipe_field_shifter: RTL and testbench

- Multi-column successor of the single-column pipe register in the game datapath.
- Holds a COLS-wide field of ROWS-bit pipe columns and scrolls it one column left at a programmable rate.
- Loads a fresh rightmost column from the pipe generator via a request pulse and scores each pipe that leaves the left edge.
- Raises the scroll speed every few passes; freezes on gameOver and clears when the game is not started. Feeds the LED-matrix driver and the score display.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_field_shifter_shift_timer.sv | 78 +++++++
 rtl/pipe_field_shifter.sv | 112 +++++++++++
 tb/tb_pipe_field_shifter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default constants for the pipe game datapath
// (field shifter, pipe generator, matrix driver).
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } pipe_state_t;

    localparam int unsigned ROWS_DEF             = 8;
    localparam int unsigned COLS_DEF             = 8;
    localparam int unsigned CNT_W_DEF            = 16;
    localparam int unsigned INIT_PERIOD_DEF      = 256;
    localparam int unsigned MIN_PERIOD_DEF       = 32;
    localparam int unsigned STEP_DEF             = 16;
    localparam int unsigned PASSES_PER_LEVEL_DEF = 4;
    localparam int unsigned SCORE_W_DEF          = 8;

endpackage

// File: rtl/pipe_field_shifter_shift_timer.sv
// Shift-rate timer: interval counter, programmable period with level
// speed-ups, and the combinational shift strobe.
module shift_timer
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W            = CNT_W_DEF,
    parameter int unsigned INIT_PERIOD      = INIT_PERIOD_DEF,
    parameter int unsigned MIN_PERIOD       = MIN_PERIOD_DEF,
    parameter int unsigned STEP             = STEP_DEF,
    parameter int unsigned PASSES_PER_LEVEL = PASSES_PER_LEVEL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic             col0_nz,
    output logic             shift_c,
    output logic [CNT_W-1:0] period
);

    localparam int unsigned PC_W = (PASSES_PER_LEVEL > 1) ? $clog2(PASSES_PER_LEVEL) : 1;
    localparam logic [CNT_W-1:0] INIT_P  = CNT_W'(INIT_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] STEP_P  = CNT_W'(STEP);
    localparam logic [CNT_W:0]   FLOOR_P = (CNT_W+1)'(MIN_PERIOD + STEP);
    localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PASSES_PER_LEVEL - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [PC_W-1:0]  pcnt_q, pcnt_d;

    assign shift_c = run && (cnt_q == '0);
    assign period  = period_q;

    // Counter advances only while running; FROZEN simply stops feeding run.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        pcnt_d   = pcnt_q;
        if (clear) begin
            cnt_d    = '0;
            period_d = INIT_P;
            pcnt_d   = '0;
        end else if (run) begin
            if (cnt_q == period_q - CNT_W'(1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (shift_c && col0_nz) begin
                if (pcnt_q == PC_LAST) begin
                    pcnt_d = '0;
                    // Compare before subtracting so the period never underflows.
                    if ({1'b0, period_q} >= FLOOR_P) begin
                        period_d = period_q - STEP_P;
                    end else begin
                        period_d = MIN_P;
                    end
                end else begin
                    pcnt_d = pcnt_q + PC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= INIT_P;
            pcnt_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pcnt_q   <= pcnt_d;
        end
    end

endmodule

// File: rtl/pipe_field_shifter.sv
// Scrolling pipe field: game FSM, column shift register, score and
// shift/pass pulses; timing comes from shift_timer.
module pipe_field_shifter
    import pipe_pkg::*;
#(
    parameter int unsigned ROWS             = ROWS_DEF,
    parameter int unsigned COLS             = COLS_DEF,
    parameter int unsigned CNT_W            = CNT_W_DEF,
    parameter int unsigned INIT_PERIOD      = INIT_PERIOD_DEF,
    parameter int unsigned MIN_PERIOD       = MIN_PERIOD_DEF,
    parameter int unsigned STEP             = STEP_DEF,
    parameter int unsigned PASSES_PER_LEVEL = PASSES_PER_LEVEL_DEF,
    parameter int unsigned SCORE_W          = SCORE_W_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 gameStart,
    input  logic                 gameOver,
    input  logic [ROWS-1:0]      newCol,
    output logic                 newColReq,
    output logic [ROWS*COLS-1:0] field,
    output logic                 shiftTick,
    output logic                 passPulse,
    output logic [SCORE_W-1:0]   score,
    output logic [CNT_W-1:0]     period
);

    localparam int unsigned FW = ROWS * COLS;

    pipe_state_t        state_q, state_d;
    logic [FW-1:0]      field_q, field_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               shift_tick_q, shift_tick_d;
    logic               pass_pulse_q, pass_pulse_d;

    logic run_c;
    logic shift_c;
    logic col0_nz_c;

    assign run_c     = (state_q == RUN) && gameStart && !gameOver;
    assign col0_nz_c = |field_q[ROWS-1:0];

    shift_timer #(
        .CNT_W           (CNT_W),
        .INIT_PERIOD     (INIT_PERIOD),
        .MIN_PERIOD      (MIN_PERIOD),
        .STEP            (STEP),
        .PASSES_PER_LEVEL(PASSES_PER_LEVEL)
    ) u_timer (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .clear  (!gameStart),
        .run    (run_c),
        .col0_nz(col0_nz_c),
        .shift_c(shift_c),
        .period (period)
    );

    // gameStart low overrides every state and clears the datapath.
    always_comb begin
        state_d      = state_q;
        field_d      = field_q;
        score_d      = score_q;
        shift_tick_d = 1'b0;
        pass_pulse_d = 1'b0;
        if (!gameStart) begin
            state_d = IDLE;
            field_d = '0;
            score_d = '0;
        end else begin
            unique case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (gameOver) state_d = FROZEN;
                FROZEN:  state_d = FROZEN;
                default: state_d = IDLE;
            endcase
            if (shift_c) begin
                field_d      = {newCol, field_q[FW-1:ROWS]};
                shift_tick_d = 1'b1;
                if (col0_nz_c) begin
                    pass_pulse_d = 1'b1;
                    if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            field_q      <= '0;
            score_q      <= '0;
            shift_tick_q <= 1'b0;
            pass_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            field_q      <= field_d;
            score_q      <= score_d;
            shift_tick_q <= shift_tick_d;
            pass_pulse_q <= pass_pulse_d;
        end
    end

    assign newColReq = shift_c;
    assign field     = field_q;
    assign score     = score_q;
    assign shiftTick = shift_tick_q;
    assign passPulse = pass_pulse_q;

endmodule

// File: tb/tb_pipe_field_shifter.sv
// Directed bench for pipe_field_shifter: per-cycle vector table for the
// run/level/zero-column phases, hand sequences for reset, freeze and clear.
module tb_pipe_field_shifter;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        gameStart;
    logic        gameOver;
    logic [3:0]  newCol;
    logic        newColReq;
    logic [11:0] field;
    logic        shiftTick;
    logic        passPulse;
    logic [7:0]  score;
    logic [15:0] period;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        gs;
        logic        go;
        logic [3:0]  col;
        logic        req;
        logic [11:0] fld;
        logic        tick;
        logic        pass;
        logic [7:0]  score;
        logic [15:0] per;
    } vec_t;

    vec_t vq[$];

    pipe_field_shifter #(
        .ROWS(4), .COLS(3), .CNT_W(16), .INIT_PERIOD(4), .MIN_PERIOD(2),
        .STEP(1), .PASSES_PER_LEVEL(2), .SCORE_W(8)
    ) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .gameStart(gameStart),
        .gameOver (gameOver),
        .newCol   (newCol),
        .newColReq(newColReq),
        .field    (field),
        .shiftTick(shiftTick),
        .passPulse(passPulse),
        .score    (score),
        .period   (period)
    );

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void r(input int gs, input int go, input int col, input int req,
                              input int fld, input int tick, input int pass,
                              input int sc, input int per);
        vec_t v;
        v.gs = 1'(gs); v.go = 1'(go); v.col = 4'(col); v.req = 1'(req);
        v.fld = 12'(fld); v.tick = 1'(tick); v.pass = 1'(pass);
        v.score = 8'(sc); v.per = 16'(per);
        vq.push_back(v);
    endfunction

    task automatic check_all(input string tag, input logic req, input logic [11:0] fld,
                             input logic tick, input logic pass, input logic [7:0] sc,
                             input logic [15:0] per);
        check({tag, " req"},    32'(newColReq), 32'(req));
        check({tag, " field"},  32'(field),     32'(fld));
        check({tag, " tick"},   32'(shiftTick), 32'(tick));
        check({tag, " pass"},   32'(passPulse), 32'(pass));
        check({tag, " score"},  32'(score),     32'(sc));
        check({tag, " period"}, 32'(period),    32'(per));
    endtask

    initial begin
        // gs go col | req field tick pass score period  (one row per clock)
        r(1,0,'hA, 0,'h000,0,0,0,4);
        r(1,0,'hA, 1,'h000,0,0,0,4);
        r(1,0,'hA, 0,'hA00,1,0,0,4);
        r(1,0,'hA, 0,'hA00,0,0,0,4);
        r(1,0,'hA, 0,'hA00,0,0,0,4);
        r(1,0,'hA, 1,'hA00,0,0,0,4);
        r(1,0,'hA, 0,'hAA0,1,0,0,4);
        r(1,0,'hA, 0,'hAA0,0,0,0,4);
        r(1,0,'hA, 0,'hAA0,0,0,0,4);
        r(1,0,'hA, 1,'hAA0,0,0,0,4);
        r(1,0,'hA, 0,'hAAA,1,0,0,4);
        r(1,0,'hA, 0,'hAAA,0,0,0,4);
        r(1,0,'hA, 0,'hAAA,0,0,0,4);
        r(1,0,'hA, 1,'hAAA,0,0,0,4);
        r(1,0,'hA, 0,'hAAA,1,1,1,4);
        r(1,0,'hA, 0,'hAAA,0,0,1,4);
        r(1,0,'hA, 0,'hAAA,0,0,1,4);
        r(1,0,'hA, 1,'hAAA,0,0,1,4);
        r(1,0,'hA, 0,'hAAA,1,1,2,3);
        r(1,0,'hA, 0,'hAAA,0,0,2,3);
        r(1,0,'hA, 1,'hAAA,0,0,2,3);
        r(1,0,'hA, 0,'hAAA,1,1,3,3);
        r(1,0,'hA, 0,'hAAA,0,0,3,3);
        r(1,0,'hA, 1,'hAAA,0,0,3,3);
        r(1,0,'hA, 0,'hAAA,1,1,4,2);
        r(1,0,'h0, 1,'hAAA,0,0,4,2);
        r(1,0,'h0, 0,'h0AA,1,1,5,2);
        r(1,0,'h0, 1,'h0AA,0,0,5,2);
        r(1,0,'h0, 0,'h00A,1,1,6,2);
        r(1,0,'h0, 1,'h00A,0,0,6,2);
        r(1,0,'h0, 0,'h000,1,1,7,2);
        r(1,0,'h5, 1,'h000,0,0,7,2);
        r(1,0,'h0, 0,'h500,1,0,7,2);
        r(1,0,'h0, 1,'h500,0,0,7,2);
        r(1,0,'h0, 0,'h050,1,0,7,2);
        r(1,1,'h0, 0,'h050,0,0,7,2);

        // Reset held with random inputs
        Reset_n   = 1'b0;
        gameStart = 1'($urandom);
        gameOver  = 1'($urandom);
        newCol    = 4'($urandom);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        #1;
        check_all("reset", 1'b0, 12'h000, 1'b0, 1'b0, 8'd0, 16'd4);

        // Released but not started: block stays idle
        Reset_n   = 1'b1;
        gameStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            gameOver = 1'($urandom);
            newCol   = 4'($urandom);
            @(negedge Clock);
            #1;
            check($sformatf("idle%0d field", i), 32'(field), 32'h0);
            check($sformatf("idle%0d req", i), 32'(newColReq), 32'h0);
        end

        // Run, speed-ups, zero-column exits, gameOver on a request cycle
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge Clock);
            gameStart = vq[i].gs;
            gameOver  = vq[i].go;
            newCol    = vq[i].col;
            #1;
            check_all($sformatf("row%0d", i), vq[i].req, vq[i].fld, vq[i].tick,
                      vq[i].pass, vq[i].score, vq[i].per);
        end

        // FROZEN: dropping gameOver changes nothing
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            gameOver = 1'b0;
            newCol   = 4'hF;
            #1;
            check_all($sformatf("frozen%0d", i), 1'b0, 12'h050, 1'b0, 1'b0, 8'd7, 16'd2);
        end

        // gameStart low clears on the next edge
        @(negedge Clock);
        gameStart = 1'b0;
        #1;
        check("stop field held", 32'(field), 32'h050);
        @(negedge Clock);
        #1;
        check_all("cleared", 1'b0, 12'h000, 1'b0, 1'b0, 8'd0, 16'd4);

        // Restart, one shift, then async reset mid-interval
        gameStart = 1'b1;
        newCol    = 4'h3;
        #1;
        check("restart idle req", 32'(newColReq), 32'h0);
        @(negedge Clock);
        #1;
        check("restart req", 32'(newColReq), 32'h1);
        @(negedge Clock);
        #1;
        check("restart field", 32'(field), 32'h300);
        check("restart tick", 32'(shiftTick), 32'h1);
        Reset_n = 1'b0;
        #1;
        check_all("async reset", 1'b0, 12'h000, 1'b0, 1'b0, 8'd0, 16'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
